enm_fire_sched: RTL and testbench
=================================

Name: enm_fire_sched

Overview:
Volley scheduler for the enemy bullet engine. It decides which of the 4 enemies launches its 3-bullet volley (vertical, left-diagonal, right-diagonal) and when. It paces volleys with a global interval and a per-enemy cooldown, and rotates fairly among eligible enemies. It sits between game control and the enemy bullet block. Per-enemy launch requests go to the bullet block; bullet-exist flags come back from it.

Parameters:
INTERVAL, 16, clk22 cycles from end of one volley handshake to next arbitration (min 1)
COOLDOWN, 48, clk22 cycles an enemy is ineligible after its volley is acknowledged (min 1)
CNT_W, 8, width of cooldown/interval counters; INTERVAL and COOLDOWN must fit

Ports:
clk22 in 1 game tick clock
rst in 1 reset, synchronous, active-high
run in 1 1 = gameplay active; 0 = pause/title
enm in 4 enemy alive flags, bit i = enemy i+1
bullet_busy in 12 bullet exist flags; bit k-1 = bullet k; enemy i owns bits i, i+4, i+8
launch_ack in 4 bullet block accepted launch for enemy i (single-cycle or level)
fire out 4 one-hot launch request, held until ack or withdrawal
fire_id out 2 index of current/last granted enemy
busy out 1 1 while in FIRE
volley_cnt out 8 acknowledged volleys, wraps 255->0

Behaviour:
- Reset values: state IDLE, fire=0, fire_id=0, busy=0, volley_cnt=0, rr_ptr=3 (first search starts at enemy 0), all cooldown[i]=0, interval counter=0.
- Reset mid-handshake: fire drops the next cycle and no ack is counted.
- Eligible(i) = enm[i] & ~bullet_busy[i] & ~bullet_busy[i+4] & ~bullet_busy[i+8] & (cooldown[i]==0).
- Cooldown counters: decrement by 1 every cycle, saturate at 0, independent of state and of run. A granted enemy's counter loads COOLDOWN on ack.
- FSM:
  - IDLE: fire=0. If run=1, load interval=INTERVAL-1 and go to WAIT.
  - WAIT: decrement interval; go to ARB in the cycle after it reads 0. INTERVAL=1 gives 1 cycle in WAIT.
  - ARB: scan i = rr_ptr+1, +2, +3, +4 (mod 4); the first eligible enemy wins. On a win: fire_id=i, fire[i]=1 registered, go to FIRE; the first fire cycle is the cycle after ARB. No eligible enemy: stay in ARB and rescan every cycle, fire=0.
  - FIRE: busy=1, fire[fire_id]=1.
    - launch_ack[fire_id]=1: next cycle fire=0, cooldown[fire_id]=COOLDOWN, rr_ptr=fire_id, volley_cnt+1, go to WAIT with interval reloaded.
    - Else if enm[fire_id]=0 (enemy died): fire=0, rr_ptr unchanged, no count, go to ARB.
    - Ack and death in the same cycle: ack wins.
    - launch_ack bits other than fire_id are ignored.
- run=0 in any state: go to IDLE next cycle, fire=0. An ack arriving in that same cycle is still honoured (cooldown, count and pointer update), then IDLE.
- fire is at most one-hot at all times. It is never asserted for an enemy whose enm bit was 0 in the previous cycle.
- All outputs are registered. Latency from WAIT expiry to fire asserted is 2 cycles (ARB cycle + register).

Optional Feature:
AIMED_PRIO_EN
- Defined: adds inputs reimux[9:0] and enmx[39:0] (enemy i x at bits 10i+9:10i) and parameter AIM_WIN (default 32). In ARB, an eligible enemy with |enmx_i - reimux| < AIM_WIN takes priority; the lowest index wins among aimed enemies. If no enemy is aimed, the normal round-robin scan applies. The distance uses an 11-bit unsigned subtract, no wrap. rr_ptr still updates to the granted id.
- Undefined: those ports and that logic do not exist; pure round-robin.

Test Plan:
1. INTERVAL=4, COOLDOWN=8, enm=4'b1111, bullet_busy=0, run rises, ack 1 cycle after each fire -> grant sequence 0,1,2,3,0; volley_cnt=5; fire one-hot every volley.
2. enm=4'b0101, enemy 2 owns bullet_busy[6]=1 -> only enemy 0 is granted; while cooldown[0]>0, FSM sits in ARB with fire=0; enemy 0 is re-granted the cycle after its cooldown reaches 0.
3. Enemy 1 granted, enm[1] drops before ack -> fire=0 next cycle; ARB grants 2 (rr_ptr still 0); volley_cnt unchanged.
4. In FIRE, launch_ack[fire_id] and enm[fire_id]=0 in the same cycle -> counted (volley_cnt+1), cooldown loaded, state WAIT.
5. run=0 during FIRE with no ack -> fire=0 next cycle, state IDLE; run=1 again -> INTERVAL cycles, then arbitration resumes from the saved rr_ptr.
6. AIMED_PRIO_EN, rr_ptr=0, reimux=200, enmx={300,205,100,190} for enemies 3..0, all eligible -> grant 0 (aimed, lowest index); move reimux=310 -> grant 3; reimux=0 -> round-robin.

Source files
------------

// File: rtl/enm_fire_sched_if.sv
// Scheduler handshake bundle: game control / bullet block drive via master, enm_fire_sched sits on slave.
// Aim-priority inputs (reimux, enmx) exist only when AIMED_PRIO_EN is defined.
interface enm_fire_sched_if;
  logic        run;
  logic [3:0]  enm;
  logic [11:0] bullet_busy;
  logic [3:0]  launch_ack;
  logic [3:0]  fire;
  logic [1:0]  fire_id;
  logic        busy;
  logic [7:0]  volley_cnt;
`ifdef AIMED_PRIO_EN
  logic [9:0]  reimux;
  logic [39:0] enmx;

  modport master (output run, enm, bullet_busy, launch_ack, reimux, enmx,
                  input  fire, fire_id, busy, volley_cnt);
  modport slave  (input  run, enm, bullet_busy, launch_ack, reimux, enmx,
                  output fire, fire_id, busy, volley_cnt);
`else
  modport master (output run, enm, bullet_busy, launch_ack,
                  input  fire, fire_id, busy, volley_cnt);
  modport slave  (input  run, enm, bullet_busy, launch_ack,
                  output fire, fire_id, busy, volley_cnt);
`endif
endinterface

// File: rtl/enm_fire_sched.sv
// Enemy volley scheduler: round-robin grant with interval/cooldown pacing; fire held until ack or death; 2 cycles WAIT expiry -> fire.
// Optional AIMED_PRIO_EN: eligible enemies horizontally close to the player win arbitration (lowest index first).
module enm_fire_sched #(
  parameter int INTERVAL = 16,
  parameter int COOLDOWN = 48,
  parameter int CNT_W    = 8
`ifdef AIMED_PRIO_EN
  , parameter int AIM_WIN = 32
`endif
) (
  input logic             clk22,
  input logic             rst,
  enm_fire_sched_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WAIT, ARB, FIRE} state_t;

  localparam logic [CNT_W-1:0] INT_LD = CNT_W'(INTERVAL - 1);
  localparam logic [CNT_W-1:0] CD_LD  = CNT_W'(COOLDOWN);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] interval_q;
  logic [CNT_W-1:0] cooldown [4];
  logic [1:0]       rr_ptr;
  logic [1:0]       fire_id_q, id_nxt;
  logic [3:0]       fire_q, fire_nxt;
  logic             busy_q, busy_nxt;
  logic [7:0]       volley_q;
  logic [3:0]       elig;
  logic             arb_found;
  logic [1:0]       arb_id;
  logic             ack_hit;

  assign ack_hit = (state == FIRE) && bus.launch_ack[fire_id_q];

  always_comb begin
    for (int i = 0; i < 4; i++)
      elig[i] = bus.enm[i] & ~bus.bullet_busy[i] & ~bus.bullet_busy[i+4] &
                ~bus.bullet_busy[i+8] & (cooldown[i] == '0);
  end

`ifdef AIMED_PRIO_EN
  function automatic logic is_aimed(input logic [9:0] x, input logic [9:0] r);
    logic [10:0] a, b, d;
    a = {1'b0, x};
    b = {1'b0, r};
    d = (a >= b) ? (a - b) : (b - a);
    return d < 11'(AIM_WIN);
  endfunction
`endif

  // Scan from rr_ptr+4 down to rr_ptr+1 so the nearest candidate is written last and wins.
  always_comb begin
    arb_found = 1'b0;
    arb_id    = 2'd0;
    for (int k = 4; k >= 1; k--) begin
      if (elig[rr_ptr + 2'(k)]) begin
        arb_found = 1'b1;
        arb_id    = rr_ptr + 2'(k);
      end
    end
`ifdef AIMED_PRIO_EN
    for (int i = 3; i >= 0; i--) begin
      if (elig[i] && is_aimed(bus.enmx[10*i +: 10], bus.reimux)) begin
        arb_found = 1'b1;
        arb_id    = 2'(i);
      end
    end
`endif
  end

  always_ff @(posedge clk22) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.run) state_nxt = WAIT;
      WAIT: if (interval_q == '0) state_nxt = ARB;
      ARB:  if (arb_found) state_nxt = FIRE;
      FIRE: begin
        if (ack_hit)                     state_nxt = WAIT;
        else if (!bus.enm[fire_id_q])    state_nxt = ARB;
      end
      default: state_nxt = IDLE;
    endcase
    if (!bus.run) state_nxt = IDLE;
  end

  always_comb begin
    id_nxt   = (state == ARB && arb_found) ? arb_id : fire_id_q;
    busy_nxt = (state_nxt == FIRE);
    fire_nxt = (state_nxt == FIRE) ? (4'b0001 << id_nxt) : 4'b0000;
  end

  always_ff @(posedge clk22) begin
    if (rst) begin
      fire_q     <= 4'b0000;
      fire_id_q  <= 2'd0;
      busy_q     <= 1'b0;
      volley_q   <= 8'd0;
      rr_ptr     <= 2'd3;
      interval_q <= '0;
      for (int i = 0; i < 4; i++) cooldown[i] <= '0;
    end else begin
      fire_q    <= fire_nxt;
      fire_id_q <= id_nxt;
      busy_q    <= busy_nxt;
      // Reload on every entry into WAIT, count down while there.
      if (state_nxt == WAIT && state != WAIT)
        interval_q <= INT_LD;
      else if (state == WAIT && interval_q != '0)
        interval_q <= interval_q - 1'b1;
      if (ack_hit) begin
        volley_q <= volley_q + 8'd1;
        rr_ptr   <= fire_id_q;
      end
      for (int i = 0; i < 4; i++) begin
        if (ack_hit && fire_id_q == 2'(i)) cooldown[i] <= CD_LD;
        else if (cooldown[i] != '0)       cooldown[i] <= cooldown[i] - 1'b1;
      end
    end
  end

  assign bus.fire       = fire_q;
  assign bus.fire_id    = fire_id_q;
  assign bus.busy       = busy_q;
  assign bus.volley_cnt = volley_q;
endmodule

// File: tb/tb_enm_fire_sched.sv
// Directed bench for enm_fire_sched with INTERVAL=4, COOLDOWN=8.
module tb_enm_fire_sched;
  logic clk22 = 1'b0;
  logic rst   = 1'b1;
  int checks = 0;
  int errors = 0;

  always #5 clk22 = ~clk22;

  enm_fire_sched_if ifc ();

  enm_fire_sched #(.INTERVAL(4), .COOLDOWN(8)) dut (
    .clk22 (clk22),
    .rst   (rst),
    .bus   (ifc)
  );

  typedef struct {
    logic [3:0]  enm;
    logic [11:0] bb;
    int          id;
    int          lat;
    int          cnt;
  } vec_t;

  vec_t tbl [5];

  task automatic tick();
    @(posedge clk22);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, got, exp);
    end
  endtask

  // Bounded wait: a missing grant shows up as a latency of 40.
  task automatic wait_fire(output int lat);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (ifc.fire == 4'b0000 && lat < 40);
  endtask

  task automatic grant(input string nm, input int exp_id, input int exp_lat);
    int lat;
    wait_fire(lat);
    chk({nm, "_lat"}, lat, exp_lat);
    chk({nm, "_fire"}, ifc.fire, 32'(4'b0001 << exp_id));
    chk({nm, "_id"}, ifc.fire_id, exp_id);
    chk({nm, "_busy"}, ifc.busy, 1);
  endtask

  task automatic ack(input string nm, input int id, input int exp_cnt);
    ifc.launch_ack = 4'b0001 << id;
    tick();
    ifc.launch_ack = 4'b0000;
    chk({nm, "_fire0"}, ifc.fire, 0);
    chk({nm, "_busy0"}, ifc.busy, 0);
    chk({nm, "_cnt"}, ifc.volley_cnt, exp_cnt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{4'hF, 12'h000, 0, 6, 1};
    tbl[1] = '{4'hF, 12'h000, 1, 5, 2};
    tbl[2] = '{4'hF, 12'h000, 2, 5, 3};
    tbl[3] = '{4'hF, 12'h000, 3, 5, 4};
    tbl[4] = '{4'hF, 12'h000, 0, 5, 5};

    ifc.run = 1'b0;
    ifc.enm = 4'h0;
    ifc.bullet_busy = 12'h000;
    ifc.launch_ack = 4'h0;
`ifdef AIMED_PRIO_EN
    ifc.reimux = 10'd0;
    ifc.enmx   = 40'd0;
`endif
    tick();
    tick();
    chk("rst_fire", ifc.fire, 0);
    chk("rst_id", ifc.fire_id, 0);
    chk("rst_busy", ifc.busy, 0);
    chk("rst_cnt", ifc.volley_cnt, 0);
    rst = 1'b0;

    // Round-robin sweep with immediate acks.
    ifc.run = 1'b1;
    for (int i = 0; i < 5; i++) begin
      ifc.enm = tbl[i].enm;
      ifc.bullet_busy = tbl[i].bb;
      grant($sformatf("rr%0d", i), tbl[i].id, tbl[i].lat);
      ack($sformatf("rr%0d", i), tbl[i].id, tbl[i].cnt);
    end

    // Enemy 1 dies while its fire is pending; rr_ptr stays 0 so 2 is next.
    grant("die_g1", 1, 5);
    ifc.enm = 4'b1101;
    tick();
    chk("die_fire0", ifc.fire, 0);
    chk("die_cnt", ifc.volley_cnt, 5);
    grant("die_g2", 2, 1);

    // Ack and death together: ack wins, back to WAIT.
    ifc.enm = 4'b1001;
    ack("ackdie", 2, 6);
    grant("ackdie_next", 3, 5);

    // Pause during FIRE without ack, then resume from saved pointer.
    ifc.run = 1'b0;
    tick();
    chk("pause_fire0", ifc.fire, 0);
    chk("pause_busy0", ifc.busy, 0);
    chk("pause_cnt", ifc.volley_cnt, 6);
    tick();
    tick();
    chk("pause_idle_fire", ifc.fire, 0);
    ifc.enm = 4'hF;
    ifc.run = 1'b1;
    grant("resume", 3, 6);

    // Ack for another enemy is ignored.
    ifc.launch_ack = 4'b0001;
    tick();
    ifc.launch_ack = 4'b0000;
    chk("wrongack_fire", ifc.fire, 4'b1000);
    chk("wrongack_cnt", ifc.volley_cnt, 6);

    // Ack in the same cycle as run drop is still counted.
    ifc.run = 1'b0;
    ack("pauseack", 3, 7);
    tick();
    ifc.run = 1'b1;
    grant("pauseack_next", 0, 6);

    // Synchronous reset mid-handshake discards the ack.
    rst = 1'b1;
    ifc.launch_ack = 4'b0001;
    tick();
    ifc.launch_ack = 4'b0000;
    chk("midrst_fire", ifc.fire, 0);
    chk("midrst_cnt", ifc.volley_cnt, 0);
    chk("midrst_id", ifc.fire_id, 0);
    chk("midrst_busy", ifc.busy, 0);
    rst = 1'b0;

    // Enemy 2 blocked by its bullet; enemy 0 waits out its cooldown in ARB.
    ifc.enm = 4'b0101;
    ifc.bullet_busy = 12'h040;
    grant("cd_g0", 0, 6);
    ack("cd_a0", 0, 1);
    grant("cd_regrant", 0, 9);
    ack("cd_a1", 0, 2);

`ifdef AIMED_PRIO_EN
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ifc.enm = 4'hF;
    ifc.bullet_busy = 12'h000;
    ifc.enmx = {10'd300, 10'd205, 10'd100, 10'd190};
    ifc.reimux = 10'd200;
    grant("aim_g0", 0, 6);
    ack("aim_a0", 0, 1);
    ifc.reimux = 10'd310;
    grant("aim_g3", 3, 5);
    ack("aim_a3", 3, 2);
    ifc.reimux = 10'd0;
    grant("aim_rr0", 0, 5);
    ack("aim_arr0", 0, 3);
    grant("aim_rr1", 1, 5);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
